// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, per-channel stability
// debounce, and one-cycle press / release / long-press event pulses.
// The release pulse port is named release_pulse because "release" is a
// reserved word in SystemVerilog and cannot be used as a plain identifier.
module button_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_state,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int LW = $clog2(LONG_CYCLES) + 1;
  localparam logic [DW-1:0]    DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0]    LP_LAST  = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0]    LP_MAX   = LW'(LONG_CYCLES);
  // Raw "not pressed" level, so leaving reset never looks like a press.
  localparam logic [WIDTH-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] s;
  logic [DW-1:0]    db_cnt [WIDTH];
  logic [LW-1:0]    lp_cnt [WIDTH];

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= IDLE_RAW;
      sync2 <= IDLE_RAW;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Normalise so that 1 always means pressed.
  assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // Accept a new level only after it has been stable for the full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_state     <= '0;
      press         <= '0;
      release_pulse <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      press         <= '0;
      release_pulse <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == btn_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_state[i]     <= s[i];
          db_cnt[i]        <= '0;
          press[i]         <= s[i];
          release_pulse[i] <= ~s[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Hold timer: counts while pressed, fires once, then saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_press <= '0;
      for (int i = 0; i < WIDTH; i++) lp_cnt[i] <= '0;
    end else begin
      long_press <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (!btn_state[i]) begin
          lp_cnt[i] <= '0;
        end else if (lp_cnt[i] != LP_MAX) begin
          lp_cnt[i] <= lp_cnt[i] + LW'(1);
          if (lp_cnt[i] == LP_LAST) long_press[i] <= 1'b1;
        end
      end
    end
  end

endmodule
